// File: rtl/pi_link_pkg.sv
// Shared link constants, FSM state encoding and the audio byte ordering for pi_link_master.
package pi_link_pkg;

   localparam logic [2:0] LINK_IDLE  = 3'd0;
   localparam logic [2:0] LINK_PORT  = 3'd1;
   localparam logic [2:0] LINK_CD    = 3'd2;
   localparam logic [2:0] LINK_AUDIO = 3'd3;
   localparam logic [2:0] LINK_MOUSE = 3'd4;

   localparam int AUDIO_FRAME_BYTES = 6;

   typedef enum logic [2:0] {
      IDLE,
      PORT_WAIT,
      PORT_POP,
      AUDIO,
      MOUSE,
      CD
   } state_t;

   // Frame order on DI: right MSB, right LSB, left MSB, left LSB, two pad bytes.
   function automatic logic [7:0] audio_byte(input logic [15:0] l, input logic [15:0] r,
                                             input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = r[15:8];
         3'd1:    b = r[7:0];
         3'd2:    b = l[15:8];
         3'd3:    b = l[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pi_link_strobe.sv
// Free-running link strobe divider: link_clk toggles every CLK_DIV clk cycles and
// rise_en_o / fall_en_o flag the clk cycle whose edge moves link_clk.
module pi_link_strobe #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic link_clk_o,
   output logic rise_en_o,
   output logic fall_en_o
);

   localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          link_clk_q;
   logic          tick;

   assign tick       = (cnt_q == CNT_MAX);
   assign rise_en_o  = tick & ~link_clk_q;
   assign fall_en_o  = tick & link_clk_q;
   assign link_clk_o = link_clk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         link_clk_q <= 1'b0;
      end else if (tick) begin
         cnt_q      <= '0;
         link_clk_q <= ~link_clk_q;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/pi_link_master.sv
// Host-side initiator of the FPGA<->Pi GPIO link: port pops, audio frames, mouse and CD writes.
// Define LINK_STATS_EN to add the stat_port_cnt / stat_audio_cnt / stat_underrun counters.
module pi_link_master
   import pi_link_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int CD_BURST_MAX = 512,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        link_clk,
   output logic [2:0]  link_state,
   output logic [7:0]  link_di,
   input  logic [7:0]  link_do,
   input  logic        fpga_tx_req,
   input  logic        fpga_rx_req,
   output logic [7:0]  port_data,
   output logic        port_valid,
   input  logic        port_ready,
   input  logic [15:0] aud_l,
   input  logic [15:0] aud_r,
   input  logic        aud_valid,
   output logic        aud_ready,
   input  logic [7:0]  mouse_data,
   input  logic        mouse_valid,
   output logic        mouse_ready,
   input  logic [7:0]  cd_data,
   input  logic        cd_valid,
   output logic        cd_ready,
   output logic        busy
`ifdef LINK_STATS_EN
   ,
   output logic [31:0] stat_port_cnt,
   output logic [31:0] stat_audio_cnt,
   output logic [15:0] stat_underrun
`endif
);

   localparam int             CDW       = $clog2(CD_BURST_MAX + 1);
   localparam logic [CDW-1:0] CD_MAX    = CDW'(CD_BURST_MAX);
   localparam logic [2:0]     AUD_LAST  = 3'(AUDIO_FRAME_BYTES - 1);

   logic rise_en;
   logic fall_en;

   pi_link_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
      .clk        (clk),
      .rst_n      (rst_n),
      .link_clk_o (link_clk),
      .rise_en_o  (rise_en),
      .fall_en_o  (fall_en)
   );

   logic [SYNC_STAGES-1:0] tx_sync_q;
   logic [SYNC_STAGES-1:0] rx_sync_q;
   logic                   tx_s;
   logic                   rx_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sync_q <= '0;
         rx_sync_q <= '0;
      end else begin
         tx_sync_q[0] <= fpga_tx_req;
         rx_sync_q[0] <= fpga_rx_req;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            tx_sync_q[i] <= tx_sync_q[i-1];
            rx_sync_q[i] <= rx_sync_q[i-1];
         end
      end
   end

   assign tx_s = tx_sync_q[SYNC_STAGES-1];
   assign rx_s = rx_sync_q[SYNC_STAGES-1];

   state_t         state_q;
   logic           armed_q;
   logic [2:0]     link_state_q;
   logic [7:0]     link_di_q;
   logic [7:0]     port_data_q;
   logic           port_valid_q;
   logic           aud_ready_q;
   logic           mouse_ready_q;
   logic           cd_ready_q;
   logic           busy_q;
   logic [15:0]    aud_l_q;
   logic [15:0]    aud_r_q;
   logic [2:0]     aud_idx_q;
   logic [CDW-1:0] cd_cnt_q;
   logic           aud_req;

   assign aud_req = aud_valid & rx_s;

   // NOTE: every register here uses <= so all branches see the pre-edge values; the
   // accept pulses are cleared at the top so each is high for exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         armed_q       <= 1'b0;
         link_state_q  <= LINK_IDLE;
         link_di_q     <= 8'h00;
         port_data_q   <= 8'h00;
         port_valid_q  <= 1'b0;
         aud_ready_q   <= 1'b0;
         mouse_ready_q <= 1'b0;
         cd_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         aud_l_q       <= 16'h0000;
         aud_r_q       <= 16'h0000;
         aud_idx_q     <= 3'd0;
         cd_cnt_q      <= '0;
      end else begin
         aud_ready_q   <= 1'b0;
         mouse_ready_q <= 1'b0;
         cd_ready_q    <= 1'b0;

         if (port_valid_q && port_ready) port_valid_q <= 1'b0;

         // The card re-arms only after sampling state 0 on a rising edge.
         if (rise_en && state_q == IDLE) armed_q <= 1'b1;

         if (fall_en) begin
            unique case (state_q)
               IDLE: begin
                  if (armed_q) begin
                     if (aud_req) begin
                        state_q      <= AUDIO;
                        busy_q       <= 1'b1;
                        armed_q      <= 1'b0;
                        link_state_q <= LINK_AUDIO;
                        link_di_q    <= audio_byte(aud_l, aud_r, 3'd0);
                        aud_l_q      <= aud_l;
                        aud_r_q      <= aud_r;
                        aud_idx_q    <= 3'd0;
                        aud_ready_q  <= 1'b1;
                     end else if (tx_s) begin
                        state_q      <= PORT_WAIT;
                        busy_q       <= 1'b1;
                        armed_q      <= 1'b0;
                        port_data_q  <= link_do;
                        port_valid_q <= 1'b1;
                     end else if (mouse_valid) begin
                        state_q       <= MOUSE;
                        busy_q        <= 1'b1;
                        armed_q       <= 1'b0;
                        link_state_q  <= LINK_MOUSE;
                        link_di_q     <= mouse_data;
                        mouse_ready_q <= 1'b1;
                     end else if (cd_valid) begin
                        state_q      <= CD;
                        busy_q       <= 1'b1;
                        armed_q      <= 1'b0;
                        link_state_q <= LINK_CD;
                        link_di_q    <= cd_data;
                        cd_ready_q   <= 1'b1;
                        cd_cnt_q     <= CDW'(1);
                     end
                  end
               end
               PORT_WAIT: begin
                  if (!port_valid_q) begin
                     state_q      <= PORT_POP;
                     link_state_q <= LINK_PORT;
                  end
               end
               AUDIO: begin
                  if (aud_idx_q == AUD_LAST) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     link_state_q <= LINK_IDLE;
                     link_di_q    <= 8'h00;
                  end else begin
                     aud_idx_q <= aud_idx_q + 3'd1;
                     link_di_q <= audio_byte(aud_l_q, aud_r_q, aud_idx_q + 3'd1);
                  end
               end
               CD: begin
                  if (aud_req || cd_cnt_q == CD_MAX || !cd_valid) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     link_state_q <= LINK_IDLE;
                     link_di_q    <= 8'h00;
                  end else begin
                     link_di_q  <= cd_data;
                     cd_ready_q <= 1'b1;
                     cd_cnt_q   <= cd_cnt_q + CDW'(1);
                  end
               end
               default: begin
                  // PORT_POP and MOUSE hold their link state for a single rising edge.
                  state_q      <= IDLE;
                  busy_q       <= 1'b0;
                  link_state_q <= LINK_IDLE;
                  link_di_q    <= 8'h00;
               end
            endcase
         end
      end
   end

   assign link_state  = link_state_q;
   assign link_di     = link_di_q;
   assign port_data   = port_data_q;
   assign port_valid  = port_valid_q;
   assign aud_ready   = aud_ready_q;
   assign mouse_ready = mouse_ready_q;
   assign cd_ready    = cd_ready_q;
   assign busy        = busy_q;

`ifdef LINK_STATS_EN
   logic [31:0] stat_port_cnt_q;
   logic [31:0] stat_audio_cnt_q;
   logic [15:0] stat_underrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_port_cnt_q  <= 32'd0;
         stat_audio_cnt_q <= 32'd0;
         stat_underrun_q  <= 16'd0;
      end else begin
         if (fall_en && state_q == PORT_POP) stat_port_cnt_q <= stat_port_cnt_q + 32'd1;
         if (fall_en && state_q == AUDIO && aud_idx_q == AUD_LAST)
            stat_audio_cnt_q <= stat_audio_cnt_q + 32'd1;
         if (rise_en && rx_s && !aud_valid && stat_underrun_q != 16'hFFFF)
            stat_underrun_q <= stat_underrun_q + 16'd1;
      end
   end

   assign stat_port_cnt  = stat_port_cnt_q;
   assign stat_audio_cnt = stat_audio_cnt_q;
   assign stat_underrun  = stat_underrun_q;
`endif

endmodule

// File: tb/tb_pi_link_master.sv
// Directed bench for pi_link_master: strobe timing, port pop, audio frame, arbitration,
// CD burst splitting and asynchronous reset mid-frame.
module tb_pi_link_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_clk;
   logic [2:0]  link_state;
   logic [7:0]  link_di;
   logic [7:0]  link_do;
   logic        fpga_tx_req;
   logic        fpga_rx_req;
   logic [7:0]  port_data;
   logic        port_valid;
   logic        port_ready;
   logic [15:0] aud_l;
   logic [15:0] aud_r;
   logic        aud_valid;
   logic        aud_ready;
   logic [7:0]  mouse_data;
   logic        mouse_valid;
   logic        mouse_ready;
   logic [7:0]  cd_data;
   logic        cd_valid;
   logic        cd_ready;
   logic        busy;
`ifdef LINK_STATS_EN
   logic [31:0] stat_port_cnt;
   logic [31:0] stat_audio_cnt;
   logic [15:0] stat_underrun;
`endif

   int checks = 0;
   int errors = 0;

   pi_link_master dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .link_clk    (link_clk),
      .link_state  (link_state),
      .link_di     (link_di),
      .link_do     (link_do),
      .fpga_tx_req (fpga_tx_req),
      .fpga_rx_req (fpga_rx_req),
      .port_data   (port_data),
      .port_valid  (port_valid),
      .port_ready  (port_ready),
      .aud_l       (aud_l),
      .aud_r       (aud_r),
      .aud_valid   (aud_valid),
      .aud_ready   (aud_ready),
      .mouse_data  (mouse_data),
      .mouse_valid (mouse_valid),
      .mouse_ready (mouse_ready),
      .cd_data     (cd_data),
      .cd_valid    (cd_valid),
      .cd_ready    (cd_ready),
      .busy        (busy)
`ifdef LINK_STATS_EN
      ,
      .stat_port_cnt  (stat_port_cnt),
      .stat_audio_cnt (stat_audio_cnt),
      .stat_underrun  (stat_underrun)
`endif
   );

   always #5 clk = ~clk;

   // What the card would sample on each link_clk rising edge: {state, di}.
   logic [10:0] rise_q[$];

   always @(posedge link_clk) begin
      #1;
      rise_q.push_back({link_state, link_di});
   end

   // link_state / link_di may only move in the clk cycle where link_clk falls.
   int         viol = 0;
   logic [2:0] prev_state = 3'd0;
   logic [7:0] prev_di = 8'h00;
   logic       prev_clk = 1'b0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if ((link_state !== prev_state || link_di !== prev_di) &&
             !(prev_clk === 1'b1 && link_clk === 1'b0))
            viol++;
      end
      prev_state = link_state;
      prev_di    = link_di;
      prev_clk   = link_clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] entry(input int i);
      if (i >= 0 && i < rise_q.size()) return rise_q[i];
      return 11'h7FF;
   endfunction

   function automatic int count_state(input logic [2:0] s);
      int n = 0;
      foreach (rise_q[i]) if (rise_q[i][10:8] == s) n++;
      return n;
   endfunction

   function automatic int first_index(input logic [2:0] s);
      foreach (rise_q[i]) if (rise_q[i][10:8] == s) return i;
      return -1;
   endfunction

   // Returns at the first clk negedge after a link_clk falling edge.
   task automatic sync_to_fall();
      logic last;
      int   c;
      last = link_clk;
      for (c = 0; c < 64; c++) begin
         @(negedge clk);
         if (last === 1'b1 && link_clk === 1'b0) break;
         last = link_clk;
      end
      check("sync_to_fall_in_time", 32'(c < 64), 32'd1);
   endtask

   initial begin
      logic [7:0]  aud_exp [6];
      logic [2:0]  runs [8];
      int          nruns, sep_err, n, hi, idx, cnt, got;
      int          len [4];
      int          start [4];
      logic [7:0]  cap;
      logic        last, prev_s;

      aud_exp = '{8'h12, 8'h34, 8'hBE, 8'hEF, 8'h00, 8'h00};

      rst_n       = 1'b0;
      link_do     = 8'h00;
      fpga_tx_req = 1'b0;
      fpga_rx_req = 1'b0;
      port_ready  = 1'b0;
      aud_l       = 16'h0000;
      aud_r       = 16'h0000;
      aud_valid   = 1'b0;
      mouse_data  = 8'h00;
      mouse_valid = 1'b0;
      cd_data     = 8'h00;
      cd_valid    = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_link_clk", 32'(link_clk), 32'd0);
      check("rst_link_state", 32'(link_state), 32'd0);
      check("rst_link_di", 32'(link_di), 32'd0);
      check("rst_port_valid", 32'(port_valid), 32'd0);
      check("rst_aud_ready", 32'(aud_ready), 32'd0);
      check("rst_mouse_ready", 32'(mouse_ready), 32'd0);
      check("rst_cd_ready", 32'(cd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // Idle strobe: 8 clk period, 4 high, state stays 0
      sync_to_fall();
      last = link_clk;
      n = 0;
      hi = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n++;
         if (link_clk === 1'b1) hi++;
         if (last === 1'b1 && link_clk === 1'b0) break;
         last = link_clk;
      end
      check("idle_period", 32'(n), 32'd8);
      check("idle_high_time", 32'(hi), 32'd4);
      rise_q.delete();
      repeat (80) @(negedge clk);
      check("idle_rises_seen", 32'(rise_q.size() >= 10), 32'd1);
      check("idle_nonzero_states", 32'(rise_q.size() - count_state(3'd0)), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Port read with consumer ready
      sync_to_fall();
      link_do     = 8'hA5;
      port_ready  = 1'b1;
      fpga_tx_req = 1'b1;
      rise_q.delete();
      got = 0;
      cap = 8'h00;
      for (int c = 0; c < 64 && got == 0; c++) begin
         @(negedge clk);
         if (port_valid === 1'b1) begin
            got = 1;
            cap = port_data;
         end
      end
      check("port_valid_seen", 32'(got), 32'd1);
      check("port_data", 32'(cap), 32'hA5);
      @(negedge clk);
      check("port_valid_pulse", 32'(port_valid), 32'd0);
      fpga_tx_req = 1'b0;
      repeat (48) @(negedge clk);
      check("port_pop_edges", 32'(count_state(3'd1)), 32'd1);
      check("port_pop_then_idle", 32'(entry(first_index(3'd1) + 1)), 32'h000);
      check("port_busy_end", 32'(busy), 32'd0);

      // Port read: tx_req drops while waiting for the consumer; the pop still happens
      sync_to_fall();
      link_do     = 8'h3C;
      port_ready  = 1'b0;
      fpga_tx_req = 1'b1;
      rise_q.delete();
      got = 0;
      for (int c = 0; c < 64 && got == 0; c++) begin
         @(negedge clk);
         if (port_valid === 1'b1) got = 1;
      end
      check("wait_valid_seen", 32'(got), 32'd1);
      fpga_tx_req = 1'b0;
      repeat (40) @(negedge clk);
      check("wait_port_data", 32'(port_data), 32'h3C);
      check("wait_valid_held", 32'(port_valid), 32'd1);
      check("wait_busy_held", 32'(busy), 32'd1);
      check("wait_no_pop_yet", 32'(count_state(3'd1)), 32'd0);
      port_ready = 1'b1;
      repeat (40) @(negedge clk);
      check("wait_pop_edges", 32'(count_state(3'd1)), 32'd1);
      check("wait_busy_end", 32'(busy), 32'd0);

      // Audio frame
      sync_to_fall();
      aud_r       = 16'h1234;
      aud_l       = 16'hBEEF;
      aud_valid   = 1'b1;
      fpga_rx_req = 1'b1;
      rise_q.delete();
      cnt = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (aud_ready === 1'b1) begin
            cnt++;
            aud_valid = 1'b0;
            aud_l     = 16'h0000;
            aud_r     = 16'h0000;
         end
      end
      fpga_rx_req = 1'b0;
      check("aud_ready_pulses", 32'(cnt), 32'd1);
      check("aud_edges", 32'(count_state(3'd3)), 32'd6);
      idx = first_index(3'd3);
      for (int k = 0; k < 6; k++)
         check($sformatf("aud_byte%0d", k), 32'(entry(idx + k)), 32'({3'd3, aud_exp[k]}));
      check("aud_then_idle", 32'(entry(idx + 6)), 32'h000);

      // All requesters at once: audio, port, mouse, CD, with idle edges between
      sync_to_fall();
      link_do     = 8'h11;
      port_ready  = 1'b1;
      aud_r       = 16'h0102;
      aud_l       = 16'h0304;
      mouse_data  = 8'h5A;
      cd_data     = 8'h77;
      aud_valid   = 1'b1;
      fpga_rx_req = 1'b1;
      fpga_tx_req = 1'b1;
      mouse_valid = 1'b1;
      cd_valid    = 1'b1;
      rise_q.delete();
      got = 0;
      for (int c = 0; c < 600 && got == 0; c++) begin
         @(negedge clk);
         if (aud_ready === 1'b1) aud_valid = 1'b0;
         if (port_valid === 1'b1) fpga_tx_req = 1'b0;
         if (mouse_ready === 1'b1) mouse_valid = 1'b0;
         if (cd_ready === 1'b1) cd_valid = 1'b0;
         if (!aud_valid && !fpga_tx_req && !mouse_valid && !cd_valid && busy === 1'b0) got = 1;
      end
      fpga_rx_req = 1'b0;
      repeat (16) @(negedge clk);
      check("prio_completed", 32'(got), 32'd1);
      nruns   = 0;
      sep_err = 0;
      runs    = '{default: 3'd0};
      prev_s  = 1'b0;
      for (int i = 0; i < rise_q.size(); i++) begin
         if (rise_q[i][10:8] != 3'd0 && (i == 0 || rise_q[i][10:8] != rise_q[i-1][10:8])) begin
            if (i > 0 && rise_q[i-1][10:8] != 3'd0) sep_err++;
            if (nruns < 8) runs[nruns] = rise_q[i][10:8];
            nruns++;
         end
      end
      check("prio_run_count", 32'(nruns), 32'd4);
      check("prio_first_audio", 32'(runs[0]), 32'd3);
      check("prio_second_port", 32'(runs[1]), 32'd1);
      check("prio_third_mouse", 32'(runs[2]), 32'd4);
      check("prio_fourth_cd", 32'(runs[3]), 32'd2);
      check("prio_idle_between", 32'(sep_err), 32'd0);
      check("prio_mouse_di", 32'(entry(first_index(3'd4))), 32'({3'd4, 8'h5A}));
      check("prio_cd_di", 32'(entry(first_index(3'd2))), 32'({3'd2, 8'h77}));
      check("prio_cd_len", 32'(count_state(3'd2)), 32'd1);

      // 600 CD bytes: 512-byte burst, one idle edge, 88-byte burst
      sync_to_fall();
      cd_data  = 8'h00;
      cd_valid = 1'b1;
      rise_q.delete();
      cnt = 0;
      got = 0;
      for (int c = 0; c < 8000 && got == 0; c++) begin
         @(negedge clk);
         if (cd_ready === 1'b1) begin
            cnt++;
            cd_data = 8'(cnt);
            if (cnt == 600) cd_valid = 1'b0;
         end
         if (cnt >= 600 && busy === 1'b0) got = 1;
      end
      cd_valid = 1'b0;
      repeat (16) @(negedge clk);
      check("cd_completed", 32'(got), 32'd1);
      check("cd_ready_pulses", 32'(cnt), 32'd600);
      nruns = 0;
      len   = '{default: 0};
      start = '{default: 0};
      for (int i = 0; i < rise_q.size(); i++) begin
         if (rise_q[i][10:8] == 3'd2) begin
            if (i == 0 || rise_q[i-1][10:8] != 3'd2) begin
               if (nruns < 4) start[nruns] = i;
               nruns++;
            end
            if (nruns <= 4) len[nruns-1]++;
         end
      end
      check("cd_burst_count", 32'(nruns), 32'd2);
      check("cd_burst0_len", 32'(len[0]), 32'd512);
      check("cd_burst1_len", 32'(len[1]), 32'd88);
      check("cd_idle_gap", 32'(start[1] - (start[0] + len[0])), 32'd1);
      check("cd_gap_state", 32'(entry(start[0] + len[0])), 32'h000);
      check("cd_burst0_last", 32'(entry(start[0] + 511)), 32'({3'd2, 8'hFF}));
      check("cd_burst1_first", 32'(entry(start[1])), 32'({3'd2, 8'h00}));
      check("cd_burst1_last", 32'(entry(start[1] + 87)), 32'({3'd2, 8'h57}));

      // Asynchronous reset during audio byte 3
      sync_to_fall();
      aud_r       = 16'hCAFE;
      aud_l       = 16'hF00D;
      aud_valid   = 1'b1;
      fpga_rx_req = 1'b1;
      rise_q.delete();
      got = 0;
      for (int c = 0; c < 100 && got == 0; c++) begin
         @(negedge clk);
         if (aud_ready === 1'b1) aud_valid = 1'b0;
         if (count_state(3'd3) >= 3) got = 1;
      end
      check("rst_mid_reached_byte3", 32'(got), 32'd1);
      check("rst_mid_pre_state", 32'(link_state), 32'd3);
      check("rst_mid_pre_di", 32'(link_di), 32'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_link_clk", 32'(link_clk), 32'd0);
      check("rst_mid_link_state", 32'(link_state), 32'd0);
      check("rst_mid_link_di", 32'(link_di), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_aud_ready", 32'(aud_ready), 32'd0);
      check("rst_mid_port_valid", 32'(port_valid), 32'd0);
      aud_valid   = 1'b0;
      fpga_rx_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rise_q.delete();
      repeat (48) @(negedge clk);
      check("post_rst_rises", 32'(rise_q.size() >= 4), 32'd1);
      check("post_rst_idle", 32'(rise_q.size() - count_state(3'd0)), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      check("state_moves_on_fall_only", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
